hough_uart_frame_bridge: RTL and testbench
==========================================

# hough_uart_frame_bridge

Host-side frame bridge for the Hough core. It collects one framed edge map from the UART receive byte stream and presents it flat on `edge_map_flat`, then pulses `start` to the Hough core. It waits for the core's `done`, captures `rho`/`theta` and serializes them as four bytes to the UART transmitter. It sits between the UART RX/TX blocks and the Hough core as the initiator/consumer end of the core's `start`/`done` interface.

## Interface
Parameters:
- `N`, 16: image side; frame payload is N*N bytes.
- `HEADER`, 8'hA5: frame start byte.
- `TIMEOUT`, 1_000_000: maximum idle cycles between payload bytes before the frame is aborted.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `rx_data`  in  8  received byte.
- `edge_map_flat`  out  8*N*N  payload byte i at bits [i*8 +: 8].
- `start`  out  1  one-cycle pulse to the Hough core.
- `done`  in  1  Hough core result-valid pulse.
- `rho`  in  16  Hough result, sampled on `done`.
- `theta`  in  16  Hough result, sampled on `done`.
- `tx_data`  out  8  byte to UART TX.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  UART TX accepts the byte.
- `busy`  out  1  high in every state except IDLE.
- `frame_err`  out  1  sticky; set on timeout, cleared when the next `HEADER` is accepted.

## Operation
- FSM states: IDLE, RECV, START, WAIT_DONE, SEND.
- **IDLE**
  - `rx_valid` with `rx_data==HEADER`: clear byte counter, gap counter and `frame_err`; go to RECV.
  - Any other byte is ignored.
- **RECV**
  - Each `rx_valid` writes `rx_data` to slot `cnt`, increments `cnt` and clears the gap counter.
  - A `HEADER` value here is payload data; there is no resync.
  - After the write of slot N*N-1, go to START.
  - If the gap counter reaches `TIMEOUT` with no byte, set `frame_err` and go to IDLE. Partially written `edge_map_flat` is retained and no `start` is issued.
  - Counter width is $clog2(N*N)+1. Gap counter width is $clog2(TIMEOUT+1).
- **START**: `start`=1 for exactly this one cycle, then go to WAIT_DONE.
- **WAIT_DONE**
  - `edge_map_flat` is held constant.
  - On `done`=1, register `rho` and `theta` into a 32-bit shift register {rho, theta}, then go to SEND.
  - There is no timeout in this state.
- **SEND**
  - Bytes go out in order rho[15:8], rho[7:0], theta[15:8], theta[7:0].
  - A transfer occurs on `tx_valid && tx_ready`.
  - After the 4th transfer, go to IDLE.
- `rx_valid` in START, WAIT_DONE or SEND: byte dropped, no effect.
- `done` outside WAIT_DONE: ignored.
- `edge_map_flat` changes only in RECV and in reset.

## Timing
- Reset values:
  - state IDLE.
  - `edge_map_flat`, `start`, `tx_valid`, `tx_data`, `busy`, `frame_err` all 0.
  - Internal counters 0.
- Reset mid-operation aborts the frame. All outputs are at reset values in the cycle after the reset edge, and no pending `start` or byte is emitted.
- All outputs are registered.
- Header accepted at edge k: `busy`=1 from k+1.
- Last payload byte accepted at edge m:
  - `start`=1 during cycle m+1..m+2 (one clock).
  - State is WAIT_DONE from m+2.
- `done` sampled at edge d: `tx_valid`=1 with `tx_data`=rho[15:8] from d+1.
- Backpressure:
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` stays stable.
  - `tx_valid` never drops before the transfer.
  - After a transfer, the next byte is presented in the following cycle.
  - With `tx_ready` tied to 1, the four bytes occupy four consecutive cycles.
- After the final transfer at edge t: `tx_valid`=0, `busy`=0 and state IDLE from t+1. A `HEADER` at edge t+1 is accepted.
- Timeout: exactly `TIMEOUT` byte-free cycles after the last accepted byte (or after the header), `frame_err` rises on the next edge.

## Test plan
- N=4, header A5 then bytes 00..0F, one byte every 3 cycles → `edge_map_flat`=0x0F0E...0100. `start` high exactly one cycle, one cycle after the last byte. `busy`=1 throughout.
- After the first test, `done` pulse with rho=16'h0102, theta=16'h005A and `tx_ready`=1 → `tx_data` 01,02,00,5A on 4 consecutive `tx_valid` cycles, then `busy`=0.
- Same as the second test but `tx_ready` held low 5 cycles on each byte → each byte stable for 6 cycles, no byte skipped or repeated, order preserved.
- TIMEOUT=20: header plus 3 bytes, then silence → `frame_err`=1 after 20 idle cycles, no `start`, state IDLE. A subsequent A5 clears `frame_err`.
- Bytes 11, 22 in IDLE are ignored. Bytes during WAIT_DONE do not alter `edge_map_flat`. A stray `done` in IDLE causes no tx.
- `reset` asserted during the second SEND byte → next cycle `tx_valid`=0, `busy`=0, `edge_map_flat`=0. A new frame then completes normally.

Source files
------------

// File: rtl/hough_uart_frame_bridge.sv
// Host-side bridge for the Hough core.
// It collects a HEADER-framed N*N byte edge map from the UART RX stream and
// pulses start to the core. It then waits for done and returns {rho, theta}
// as four bytes on the TX handshake, MSB first.
module hough_uart_frame_bridge #(
    parameter int         N       = 16,
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic [8*N*N-1:0]     edge_map_flat,
    output logic                 start,
    input  logic                 done,
    input  logic [15:0]          rho,
    input  logic [15:0]          theta,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int NN = N * N;
    localparam int CW = $clog2(NN) + 1;
    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECV      = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        SEND      = 3'd4
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   cnt_r;
    logic [GW-1:0]   gap_r;
    logic [31:0]     shift_r;     // bytes still to send after the one on tx_data
    logic [1:0]      byte_idx_r;
    logic            rx_hdr_s;
    logic            last_byte_s;
    logic            timeout_s;
    logic            tx_fire_s;

    // Decode the handshake, frame-end and timeout conditions used by both processes.
    always_comb begin
        rx_hdr_s    = rx_valid && (rx_data == HEADER);
        last_byte_s = rx_valid && (cnt_r == CW'(NN - 1));
        timeout_s   = !rx_valid && (gap_r == GW'(TIMEOUT));
        tx_fire_s   = tx_valid && tx_ready;
    end

    // Next-state logic for the frame / compute / reply sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx_hdr_s) next_state_s = RECV;
                else          next_state_s = IDLE;
            end
            RECV: begin
                if (last_byte_s)    next_state_s = START;
                else if (timeout_s) next_state_s = IDLE;
                else                next_state_s = RECV;
            end
            START: next_state_s = WAIT_DONE;
            WAIT_DONE: begin
                if (done) next_state_s = SEND;
                else      next_state_s = WAIT_DONE;
            end
            SEND: begin
                if (tx_fire_s && (byte_idx_r == 2'd3)) next_state_s = IDLE;
                else                                   next_state_s = SEND;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Datapath and registered outputs; flags come from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_map_flat <= '0;
            start         <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'h00;
            busy          <= 1'b0;
            frame_err     <= 1'b0;
            cnt_r         <= '0;
            gap_r         <= '0;
            shift_r       <= 32'h0000_0000;
            byte_idx_r    <= 2'd0;
        end else begin
            busy     <= (next_state_s != IDLE);
            start    <= (next_state_s == START);
            tx_valid <= (next_state_s == SEND);
            case (state_r)
                IDLE: begin
                    if (rx_hdr_s) begin
                        cnt_r     <= '0;
                        gap_r     <= '0;
                        frame_err <= 1'b0;
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        edge_map_flat[cnt_r[CW-2:0] * 32'd8 +: 8] <= rx_data;
                        cnt_r <= cnt_r + CW'(1);
                        gap_r <= '0;
                    end else if (timeout_s) begin
                        frame_err <= 1'b1;
                    end else begin
                        gap_r <= gap_r + GW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        tx_data    <= rho[15:8];
                        shift_r    <= {rho[7:0], theta, 8'h00};
                        byte_idx_r <= 2'd0;
                    end
                end
                SEND: begin
                    if (tx_fire_s) begin
                        tx_data    <= shift_r[31:24];
                        shift_r    <= shift_r << 8;
                        byte_idx_r <= byte_idx_r + 2'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hough_uart_frame_bridge.sv
// Scoreboard bench for hough_uart_frame_bridge (N=4, TIMEOUT=20).
// Stimulus pushes the expected reply bytes into a queue. A negedge monitor
// compares whatever the DUT presents on TX and pops each byte on transfer.
module tb_hough_uart_frame_bridge;

    localparam int         N   = 4;
    localparam int         NN  = N * N;
    localparam int         W   = 8 * NN;
    localparam int         TO  = 20;
    localparam logic [7:0] HDR = 8'hA5;

    logic          clk = 1'b0;
    logic          reset, rx_valid, done, tx_ready;
    logic [7:0]    rx_data;
    logic [15:0]   rho, theta;
    logic [W-1:0]  edge_map_flat;
    logic          start, tx_valid, busy, frame_err;
    logic [7:0]    tx_data;

    hough_uart_frame_bridge #(.N(N), .HEADER(HDR), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .edge_map_flat(edge_map_flat), .start(start), .done(done),
        .rho(rho), .theta(theta), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model[NN];
    int         exp_hold    = 1;
    int         starts_seen = 0;
    int         exp_starts  = 0;
    int         hold        = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] flat_model();
        logic [W-1:0] f;
        for (int i = 0; i < NN; i++) f[i*8 +: 8] = model[i];
        return f;
    endfunction

    // Monitor: count start pulses and score every presented TX byte.
    always @(negedge clk) begin
        if (start === 1'b1) starts_seen++;
        if (reset !== 1'b0) begin
            hold = 0;
        end else if (tx_valid === 1'b1) begin
            hold++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got byte %0h with nothing expected", tx_data);
            end else begin
                chk("tx_byte", W'(tx_data), W'(exp_q[0]));
                if (tx_ready) begin
                    if (exp_hold != 0) chk("tx_hold", W'(hold), W'(exp_hold));
                    void'(exp_q.pop_front());
                    hold = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_payload(input int count, input bit incr);
        logic [7:0] b;
        for (int i = 0; i < count; i++) begin
            b = incr ? 8'(i) : 8'($urandom_range(0, 255));
            if (!incr && i == 5) b = HDR;
            send_byte(b);
            model[i] = b;
            if (i != count - 1) repeat (2) tick();
        end
    endtask

    task automatic full_frame(input bit incr);
        send_byte(HDR);
        chk("busy_after_header", W'(busy), W'(1));
        chk("err_after_header", W'(frame_err), W'(0));
        send_payload(NN, incr);
        chk("start_pulse", W'(start), W'(1));
        exp_starts++;
        tick();
        chk("start_once", W'(start), W'(0));
        chk("busy_wait", W'(busy), W'(1));
        chk("edge_map", edge_map_flat, flat_model());
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || tx_valid) && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) begin
            n_checks++;
            $display("FAIL tx_drain_timeout: %0d bytes still expected", exp_q.size());
        end
        chk("busy_after_send", W'(busy), W'(0));
    endtask

    // mode 0: tx_ready tied high; mode 1: 5 stall cycles per byte.
    task automatic run_done(input logic [15:0] r, input logic [15:0] t, input int mode);
        exp_hold = (mode == 0) ? 1 : 6;
        tx_ready = (mode == 0);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(t[15:8]);
        exp_q.push_back(t[7:0]);
        rho   = r;
        theta = t;
        done  = 1'b1;
        tick();
        done  = 1'b0;
        if (mode == 1) begin
            repeat (4) begin
                repeat (5) tick();
                tx_ready = 1'b1;
                tick();
                tx_ready = 1'b0;
            end
        end
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; done = 1'b0;
        tx_ready = 1'b0; rho = 16'h0000; theta = 16'h0000;
        for (int i = 0; i < NN; i++) model[i] = 8'h00;
        tick(); tick();
        reset = 1'b0;
        chk("rst_edge_map", edge_map_flat, '0);
        chk("rst_start", W'(start), W'(0));
        chk("rst_tx_valid", W'(tx_valid), W'(0));
        chk("rst_tx_data", W'(tx_data), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_frame_err", W'(frame_err), W'(0));

        // Junk bytes and a stray done while idle.
        send_byte(8'h11);
        send_byte(8'h22);
        chk("idle_ignore_busy", W'(busy), W'(0));
        done = 1'b1; tick(); done = 1'b0;
        repeat (3) tick();
        chk("stray_done_tx", W'(tx_valid), W'(0));
        chk("stray_done_busy", W'(busy), W'(0));

        // Counting pattern frame, then bytes during WAIT_DONE.
        full_frame(1'b1);
        chk("edge_map_pattern", edge_map_flat, 128'h0F0E0D0C0B0A09080706050403020100);
        send_byte(8'($urandom_range(0, 255)));
        send_byte(HDR);
        chk("edge_map_hold", edge_map_flat, flat_model());
        run_done(16'h0102, 16'h005A, 0);

        // Backpressured reply on a random frame.
        full_frame(1'b0);
        run_done(16'($urandom), 16'($urandom), 1);

        // Timeout: header plus three bytes then silence.
        send_byte(HDR);
        send_payload(3, 1'b0);
        repeat (TO) tick();
        chk("err_before_timeout", W'(frame_err), W'(0));
        tick();
        chk("err_at_timeout", W'(frame_err), W'(1));
        chk("busy_at_timeout", W'(busy), W'(0));
        chk("edge_map_partial", edge_map_flat, flat_model());
        send_byte(HDR);
        chk("err_cleared", W'(frame_err), W'(0));
        repeat (TO + 5) tick();
        chk("err_second_timeout", W'(frame_err), W'(1));

        // Reset during the second reply byte.
        full_frame(1'b0);
        exp_hold = 0;
        tx_ready = 1'b0;
        rho = 16'($urandom); theta = 16'($urandom);
        exp_q.push_back(rho[15:8]);
        exp_q.push_back(rho[7:0]);
        exp_q.push_back(theta[15:8]);
        exp_q.push_back(theta[7:0]);
        done = 1'b1; tick(); done = 1'b0;
        tx_ready = 1'b1; tick();
        tx_ready = 1'b0; tick();
        reset = 1'b1; tick(); reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NN; i++) model[i] = 8'h00;
        chk("rstmid_tx_valid", W'(tx_valid), W'(0));
        chk("rstmid_busy", W'(busy), W'(0));
        chk("rstmid_edge_map", edge_map_flat, '0);
        chk("rstmid_tx_data", W'(tx_data), W'(0));
        chk("rstmid_start", W'(start), W'(0));
        repeat (3) tick();
        chk("rstmid_quiet", W'(tx_valid), W'(0));

        // A fresh frame after the abort.
        full_frame(1'b0);
        run_done(16'($urandom), 16'($urandom), 0);

        repeat (3) tick();
        chk("start_count", W'(starts_seen), W'(exp_starts));
        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
